// File: rtl/serial_sched_pkg.sv
// Shared types and helpers for the serial lane scheduler.
// The optional trailing parity bit is built only when PARITY_EN is defined.
package serial_sched_pkg;

  // Upper bound on requesters that rr_pick can scan.
  localparam int MAX_REQ = 64;

  // FSM state encoding; PAR is reachable only when the parity bit is built.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    PAR   = 2'd3
  } state_e;

  // Pointer / select width for n requesters (at least 1 bit).
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bit counter width for a w-bit frame (at least 1 bit).
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  // First set request scanning ptr, ptr+1, ... wrapping modulo n.
  // Returns ptr when nothing is requested; callers gate with any_req.
  function automatic int rr_pick(input logic [MAX_REQ-1:0] req,
                                 input int ptr,
                                 input int n);
    int  idx;
    int  pick;
    bit  found;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (i < n) begin
        idx = ptr + i;
        if (idx >= n) idx = idx - n;
        if (!found && req[idx]) begin
          pick  = idx;
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/serial_lane_scheduler_rr_arbiter.sv
// Combinational round-robin index selection: the winner is the first active
// request at or after ptr, wrapping modulo NUM_REQ.
module rr_arbiter
  import serial_sched_pkg::*;
#(
  parameter int NUM_REQ = 8,
  parameter int PTR_W   = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [PTR_W-1:0]   sel,
  output logic               any_req
);

  logic [MAX_REQ-1:0] req_ext;

  // Widen the request vector to the scan width of rr_pick and select.
  always_comb begin
    req_ext = MAX_REQ'(req);
    any_req = |req;
    sel     = PTR_W'(rr_pick(req_ext, int'(ptr), NUM_REQ));
  end

endmodule

// File: rtl/serial_lane_scheduler.sv
// Round-robin scheduler draining NUM_REQ word sources through one
// bit-serial lane, LSB first, with a start marker on the first bit.
// Optional feature: define PARITY_EN to append an even-parity bit per frame.
//
// Handshake: a requester holds req[i] high with data stable until grant[i]
// pulses for one cycle; the word is captured in that cycle and req may drop
// afterwards. Dropping req before the grant cancels the pick without a grant.
module serial_lane_scheduler
  import serial_sched_pkg::*;
#(
  parameter int NUM_REQ = 8,
  parameter int DATA_W  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   data,
  output logic [NUM_REQ-1:0]          grant,
  output logic                        ser_out,
  output logic                        ser_valid,
  output logic                        ser_start,
  output logic                        busy,
  output logic [1:0]                  dbg_state
);

  localparam int PTR_W = ptr_w(NUM_REQ);
  localparam int CNT_W = cnt_w(DATA_W);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_LOAD  = LOAD;
  localparam logic [1:0] S_SHIFT = SHIFT;
`ifdef PARITY_EN
  localparam logic [1:0] S_PAR   = PAR;
`endif

  localparam logic [PTR_W-1:0] LAST_REQ = PTR_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic [1:0]        state;
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  sel;
  logic [PTR_W-1:0]  pick_sel;
  logic              any_req;
  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  bit_cnt;
`ifdef PARITY_EN
  logic              par;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req     (req),
    .ptr     (rr_ptr),
    .sel     (pick_sel),
    .any_req (any_req)
  );

  // FSM, selection latch, shift register, bit counter and parity accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      rr_ptr  <= '0;
      sel     <= '0;
      shreg   <= '0;
      bit_cnt <= '0;
`ifdef PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            sel   <= pick_sel;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (req[sel]) begin
            shreg   <= data[int'(sel)*DATA_W +: DATA_W];
            rr_ptr  <= (sel == LAST_REQ) ? '0 : sel + PTR_W'(1);
            bit_cnt <= '0;
`ifdef PARITY_EN
            par     <= 1'b0;
`endif
            state   <= S_SHIFT;
          end else begin
            state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          shreg   <= shreg >> 1;
          bit_cnt <= bit_cnt + CNT_W'(1);
`ifdef PARITY_EN
          par     <= par ^ shreg[0];
          if (bit_cnt == LAST_BIT) state <= S_PAR;
`else
          if (bit_cnt == LAST_BIT) state <= S_IDLE;
`endif
        end
`ifdef PARITY_EN
        S_PAR: state <= S_IDLE;
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  // Grant is the latched selection qualified by the requester still holding
  // req; the arbitration itself never sits between req and grant.
  always_comb begin
    grant = '0;
    if (state == S_LOAD && req[sel]) grant[sel] = 1'b1;
  end

  // Lane outputs decode from state, shift register, counter and parity flop.
  always_comb begin
    ser_out   = 1'b0;
    ser_valid = 1'b0;
    ser_start = 1'b0;
    if (state == S_SHIFT) begin
      ser_out   = shreg[0];
      ser_valid = 1'b1;
      ser_start = (bit_cnt == '0);
    end
`ifdef PARITY_EN
    else if (state == S_PAR) begin
      ser_out   = par;
      ser_valid = 1'b1;
    end
`endif
  end

  // Status outputs.
  always_comb begin
    busy      = (state != S_IDLE);
    dbg_state = state;
  end

endmodule

// File: tb/tb_serial_lane_scheduler.sv
// Self-checking bench for serial_lane_scheduler with a frame-level model:
// expected winner from a round-robin scan, expected bits from the word.
// Define PARITY_EN for both bench and RTL to exercise the parity bit.
module tb_serial_lane_scheduler;

  localparam int NUM_REQ = 8;
  localparam int DATA_W  = 16;
`ifdef PARITY_EN
  localparam int FRAME_BITS = DATA_W + 1;
`else
  localparam int FRAME_BITS = DATA_W;
`endif
  localparam int PERIOD = 2 + FRAME_BITS;

  logic                       clk;
  logic                       rst;
  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ*DATA_W-1:0]  data;
  logic [NUM_REQ-1:0]         grant;
  logic                       ser_out;
  logic                       ser_valid;
  logic                       ser_start;
  logic                       busy;
  logic [1:0]                 dbg_state;

  logic [DATA_W-1:0] words [NUM_REQ];
  logic [DATA_W-1:0] exp_q [$];

  int checks;
  int errors;
  int model_ptr;
  int cyc_cnt;

  serial_lane_scheduler #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .data      (data),
    .grant     (grant),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .ser_start (ser_start),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt = cyc_cnt + 1;

  // Pack the per-requester words onto the data bus.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) data[i*DATA_W +: DATA_W] = words[i];
  end

  // Advance one cycle; sample point is 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference pick: first requester at or after the pointer, modulo NUM_REQ.
  function automatic int exp_pick(input logic [NUM_REQ-1:0] r, input int p);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r[(p + i) % NUM_REQ]) return (p + i) % NUM_REQ;
    end
    return -1;
  endfunction

  // One full transaction from an IDLE cycle: pick, grant, frame, back to IDLE.
  task automatic run_one(input logic [NUM_REQ-1:0] reqv, input bit release_req,
                         output int grant_cyc);
    int                w;
    logic [DATA_W-1:0] word;
    logic [NUM_REQ-1:0] exp_g;
    req = reqv;
    #1;
    checks++;
    if (grant !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_cycle grant=%h busy=%b required grant=0 busy=0", grant, busy);
    end
    w = exp_pick(reqv, model_ptr);
    exp_q.push_back(words[w]);
    tick();
    exp_g = '0;
    exp_g[w] = 1'b1;
    grant_cyc = cyc_cnt;
    checks++;
    if (grant !== exp_g || ser_valid !== 1'b0) begin
      errors++;
      $display("FAIL grant got=%h required=%h ser_valid=%b", grant, exp_g, ser_valid);
    end
    model_ptr = (w + 1) % NUM_REQ;
    tick();
    if (release_req) req[w] = 1'b0;
    word = exp_q.pop_front();
    for (int b = 0; b < DATA_W; b++) begin
      checks++;
      if (ser_valid !== 1'b1 || ser_out !== word[b] || ser_start !== (b == 0)) begin
        errors++;
        $display("FAIL frame_bit%0d word=%h out=%b valid=%b start=%b required out=%b valid=1 start=%b",
                 b, word, ser_out, ser_valid, ser_start, word[b], (b == 0));
      end
      tick();
    end
`ifdef PARITY_EN
    checks++;
    if (ser_valid !== 1'b1 || ser_out !== (^word) || ser_start !== 1'b0) begin
      errors++;
      $display("FAIL parity_bit word=%h out=%b valid=%b start=%b required out=%b",
               word, ser_out, ser_valid, ser_start, ^word);
    end
    tick();
`endif
    checks++;
    if (ser_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL frame_end valid=%b busy=%b required 0 0", ser_valid, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0;
    tick();
    tick();
    checks++;
    if (grant !== '0 || ser_out !== 1'b0 || ser_valid !== 1'b0 ||
        ser_start !== 1'b0 || busy !== 1'b0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset grant=%h out=%b valid=%b start=%b busy=%b state=%0d required all 0",
               grant, ser_out, ser_valid, ser_start, busy, dbg_state);
    end
    rst = 1'b0;
    model_ptr = 0;
    tick();
  endtask

  task automatic test_single();
    int gc;
    words[3] = 16'hA5C3;
    run_one(8'h08, 1'b1, gc);
    req = '0;
    tick();
  endtask

  task automatic test_round_robin();
    int gc;
    words[2] = 16'h1234;
    words[5] = 16'hBEEF;
    run_one(8'h24, 1'b1, gc);
    run_one(req, 1'b1, gc);
    req = '0;
    tick();
  endtask

  task automatic test_back_to_back();
    int gc;
    int prev;
    int exp_first;
    for (int i = 0; i < NUM_REQ; i++) words[i] = DATA_W'($urandom);
    exp_first = model_ptr;
    run_one(8'hFF, 1'b0, prev);
    for (int k = 1; k <= NUM_REQ; k++) begin
      run_one(8'hFF, 1'b0, gc);
      checks++;
      if (gc - prev !== PERIOD) begin
        errors++;
        $display("FAIL grant_spacing k=%0d got=%0d required=%0d", k, gc - prev, PERIOD);
      end
      prev = gc;
    end
    checks++;
    if (model_ptr !== (exp_first + NUM_REQ + 1) % NUM_REQ) begin
      errors++;
      $display("FAIL wrap_order ptr=%0d required=%0d", model_ptr, (exp_first + 1) % NUM_REQ);
    end
    req = '0;
    tick();
  endtask

  task automatic test_reset_mid_frame();
    int gc;
    words[6] = 16'h5A5A;
    req = 8'h40;
    tick();
    tick();
    req = '0;
    for (int b = 0; b < 7; b++) tick();
    checks++;
    if (ser_valid !== 1'b1 || ser_out !== words[6][7]) begin
      errors++;
      $display("FAIL mid_frame_bit7 valid=%b out=%b required 1 %b", ser_valid, ser_out, words[6][7]);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (ser_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_truncate valid=%b busy=%b required 0 0", ser_valid, busy);
    end
    model_ptr = 0;
    words[0] = 16'h0F0F;
    words[1] = 16'hF00F;
    run_one(8'h03, 1'b1, gc);
    checks++;
    if (model_ptr !== 1) begin
      errors++;
      $display("FAIL post_reset_ptr got=%0d required=1", model_ptr);
    end
    req = '0;
    tick();
  endtask

  task automatic test_request_dropped();
    int gc;
    words[4] = 16'hC0DE;
    req = 8'h10;
    tick();
    req = '0;
    #1;
    checks++;
    if (grant !== '0 || ser_valid !== 1'b0) begin
      errors++;
      $display("FAIL drop_load grant=%h valid=%b required 0 0", grant, ser_valid);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || ser_valid !== 1'b0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL drop_idle busy=%b valid=%b state=%0d required 0 0 0", busy, ser_valid, dbg_state);
    end
    tick();
    for (int i = 0; i < NUM_REQ; i++) words[i] = DATA_W'($urandom);
    run_one(8'hFF, 1'b1, gc);
    req = '0;
    tick();
  endtask

  task automatic test_random();
    int gc;
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < NUM_REQ; i++) words[i] = DATA_W'($urandom);
      run_one(NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1)), 1'b1, gc);
      if ($urandom_range(0, 1) == 1) begin
        req = '0;
        tick();
      end
    end
    req = '0;
    tick();
  endtask

`ifdef PARITY_EN
  task automatic test_parity();
    int gc;
    words[1] = 16'h0001;
    run_one(NUM_REQ'(1) << 1, 1'b1, gc);
    req = '0;
    tick();
  endtask
`endif

  initial begin
    checks  = 0;
    errors  = 0;
    cyc_cnt = 0;
    rst     = 1'b1;
    req     = '0;
    for (int i = 0; i < NUM_REQ; i++) words[i] = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_request_dropped();
    test_reset_mid_frame();
    test_random();
`ifdef PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
